// File: rtl/voxel_bin_scheduler.sv
// voxel_bin_scheduler
//
// Sequences the voxel-bin accumulation RAM from the decoded event stream.
// Keeps a ring of NUM_BINS temporal bins and detects bin rollover from event
// timestamps. Each accepted event becomes an increment command.
// Once the ring is full, every rollover hands the completed window to the
// classifier with a req/ack handshake. The bin about to be reused is then
// cleared before the event that caused the rollover is written into it.
//
// Ports:
//   clk         clock
//   rst         asynchronous reset, active-low
//   ev_valid    single-cycle event strobe (no backpressure)
//   ev_x, ev_y  grid coordinates
//   ev_pol      event polarity
//   ev_ts       16-bit event timestamp, wraps modulo 2^16
//   inc_en      increment the voxel at inc_addr
//   inc_addr    voxel address {bin, pol, y, x}
//   clr_en      write zero at clr_addr
//   clr_addr    voxel address being cleared
//   win_req     a completed window is ready for the classifier
//   win_oldest  oldest bin of the window (read order oldest..cur_bin)
//   win_ack     classifier has finished reading the window
//   cur_bin     bin currently accumulating
//   busy        high while events would be dropped (init sweep, handshake,
//               bin clear, flush)
//   drop_count  saturating count of discarded events

module voxel_bin_scheduler #(
    parameter int GRID_BITS  = 4,
    parameter int NUM_BINS   = 4,
    parameter int BIN_PERIOD = 1000,
    // Derived widths; leave at their defaults.
    parameter int BIN_W      = $clog2(NUM_BINS),
    parameter int ADDR_W     = BIN_W + 1 + 2*GRID_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ev_valid,
    input  logic [GRID_BITS-1:0] ev_x,
    input  logic [GRID_BITS-1:0] ev_y,
    input  logic                 ev_pol,
    input  logic [15:0]          ev_ts,
    output logic                 inc_en,
    output logic [ADDR_W-1:0]    inc_addr,
    output logic                 clr_en,
    output logic [ADDR_W-1:0]    clr_addr,
    output logic                 win_req,
    output logic [BIN_W-1:0]     win_oldest,
    input  logic                 win_ack,
    output logic [BIN_W-1:0]     cur_bin,
    output logic                 busy,
    output logic [15:0]          drop_count
);

    // Width of the in-bin part of a voxel address: {pol, y, x}.
    localparam int SUB_W = 1 + 2*GRID_BITS;

    localparam logic [ADDR_W-1:0] INIT_LAST = '1;
    localparam logic [SUB_W-1:0]  CLR_LAST  = '1;
    localparam logic [BIN_W:0]    FULL      = (BIN_W+1)'(NUM_BINS);
    localparam logic [15:0]       PERIOD    = 16'(BIN_PERIOD);
    localparam logic [15:0]       PERIOD_X2 = 16'(2*BIN_PERIOD);

    typedef enum logic [2:0] {
        S_INIT_CLR,
        S_WAIT_FIRST,
        S_ACCUM,
        S_WIN_REQ,
        S_CLEAR,
        S_FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    logic              active;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [15:0]       bin_start;
    logic [BIN_W:0]    filled;
    logic [SUB_W-1:0]  pending;

    logic [SUB_W-1:0]  ev_sub;
    logic [15:0]       elapsed;
    logic              is_late;
    logic              is_roll;
    logic              is_gap;
    logic [BIN_W:0]    filled_inc;
    logic              drop;

    assign ev_sub  = {ev_pol, ev_y, ev_x};
    assign elapsed = ev_ts - bin_start;

    // A modular difference with the top bit set means the event is older
    // than the bin start. Such late events are folded into the current bin
    // and never cause a rollover.
    assign is_late    = elapsed[15];
    assign is_roll    = !is_late && (elapsed >= PERIOD);
    assign is_gap     = elapsed >= PERIOD_X2;
    assign filled_inc = (filled == FULL) ? filled : filled + (BIN_W+1)'(1);

    assign drop = ev_valid && (state == S_INIT_CLR || state == S_WIN_REQ ||
                               state == S_CLEAR    || state == S_FLUSH);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_INIT_CLR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded outputs.
    // The init sweep is qualified by 'active' so that nothing is driven
    // while reset is held. The sweep starts on the first edge after release.
    always_comb begin
        state_next = state;
        clr_en     = 1'b0;
        clr_addr   = '0;
        win_req    = 1'b0;
        win_oldest = '0;
        busy       = 1'b0;
        case (state)
            S_INIT_CLR: begin
                if (active) begin
                    clr_en   = 1'b1;
                    clr_addr = sweep_cnt;
                    busy     = 1'b1;
                    if (sweep_cnt == INIT_LAST) begin
                        state_next = S_WAIT_FIRST;
                    end
                end
            end
            S_WAIT_FIRST: begin
                if (ev_valid) begin
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (ev_valid && is_roll) begin
                    state_next = (filled_inc == FULL) ? S_WIN_REQ : S_CLEAR;
                end
            end
            S_WIN_REQ: begin
                busy       = 1'b1;
                win_req    = 1'b1;
                win_oldest = cur_bin + BIN_W'(1);
                if (win_ack) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy     = 1'b1;
                clr_en   = 1'b1;
                clr_addr = {cur_bin, sweep_cnt[SUB_W-1:0]};
                if (sweep_cnt[SUB_W-1:0] == CLR_LAST) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy       = 1'b1;
                state_next = S_ACCUM;
            end
            default: begin
                state_next = S_INIT_CLR;
            end
        endcase
    end

    // Datapath: bin bookkeeping, sweep counter, increment command and drop
    // counter. cur_bin advances on the transition into CLEAR. The clear sweep
    // and the pending flush therefore already target the reused bin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active     <= 1'b0;
            sweep_cnt  <= '0;
            bin_start  <= '0;
            filled     <= '0;
            pending    <= '0;
            cur_bin    <= '0;
            inc_en     <= 1'b0;
            inc_addr   <= '0;
            drop_count <= '0;
        end else begin
            active <= 1'b1;
            inc_en <= 1'b0;
            if (drop && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            case (state)
                S_INIT_CLR: begin
                    if (active) begin
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    end
                end
                S_WAIT_FIRST: begin
                    if (ev_valid) begin
                        bin_start <= ev_ts;
                        cur_bin   <= '0;
                        inc_en    <= 1'b1;
                        inc_addr  <= {{BIN_W{1'b0}}, ev_sub};
                    end
                end
                S_ACCUM: begin
                    if (ev_valid) begin
                        if (!is_roll) begin
                            inc_en   <= 1'b1;
                            inc_addr <= {cur_bin, ev_sub};
                        end else begin
                            pending   <= ev_sub;
                            filled    <= filled_inc;
                            sweep_cnt <= '0;
                            // A gap of two or more periods resyncs the bin
                            // start to this event. Either way only one bin
                            // advance happens.
                            bin_start <= is_gap ? ev_ts : bin_start + PERIOD;
                            if (filled_inc != FULL) begin
                                cur_bin <= cur_bin + BIN_W'(1);
                            end
                        end
                    end
                end
                S_WIN_REQ: begin
                    if (win_ack) begin
                        cur_bin   <= cur_bin + BIN_W'(1);
                        sweep_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    if (sweep_cnt[SUB_W-1:0] == CLR_LAST) begin
                        inc_en   <= 1'b1;
                        inc_addr <= {cur_bin, pending};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voxel_bin_scheduler.sv
// tb_voxel_bin_scheduler
//
// Directed bench for voxel_bin_scheduler. Each event vector carries an
// expected voxel address computed by hand as {bin, pol, y, x}.
// The bench covers:
//   - reset values and the full init sweep;
//   - in-bin, boundary and late events;
//   - rollovers with bin clears and a drop during a clear;
//   - the window handshake with drops while waiting, including a saturated
//     ring;
//   - reset in the middle of a clear;
//   - timestamp wrap and the resync after a long gap.

module tb_voxel_bin_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ev_valid = 1'b0;
    logic [3:0]  ev_x = '0;
    logic [3:0]  ev_y = '0;
    logic        ev_pol = 1'b0;
    logic [15:0] ev_ts = '0;
    logic        win_ack = 1'b0;
    logic        inc_en;
    logic [10:0] inc_addr;
    logic        clr_en;
    logic [10:0] clr_addr;
    logic        win_req;
    logic [1:0]  win_oldest;
    logic [1:0]  cur_bin;
    logic        busy;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    voxel_bin_scheduler #(
        .GRID_BITS (4),
        .NUM_BINS  (4),
        .BIN_PERIOD(1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_valid  (ev_valid),
        .ev_x      (ev_x),
        .ev_y      (ev_y),
        .ev_pol    (ev_pol),
        .ev_ts     (ev_ts),
        .inc_en    (inc_en),
        .inc_addr  (inc_addr),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr),
        .win_req   (win_req),
        .win_oldest(win_oldest),
        .win_ack   (win_ack),
        .cur_bin   (cur_bin),
        .busy      (busy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Single comparison point. Every check counts here.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one event for a single cycle. Returns one cycle after the
    // sampling edge, which is where a 1-cycle-latency increment is visible.
    task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y,
                                 input logic pol, input logic [15:0] ts);
        ev_x     = x;
        ev_y     = y;
        ev_pol   = pol;
        ev_ts    = ts;
        ev_valid = 1'b1;
        tick();
        ev_valid = 1'b0;
    endtask

    // Event that must land in the current bin.
    task automatic inBinEvent(input string tag, input logic [3:0] x,
                              input logic [3:0] y, input logic pol,
                              input logic [15:0] ts, input logic [10:0] addr,
                              input logic [1:0] bin);
        applyStimulus(x, y, pol, ts);
        checkOutput({tag, "_inc_en"}, inc_en, 1);
        checkOutput({tag, "_inc_addr"}, inc_addr, addr);
        checkOutput({tag, "_cur_bin"}, cur_bin, bin);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // Called on the first cycle after reset release. Expects 2048
    // consecutive clear cycles at addresses 0..2047, then an idle state.
    task automatic initSweep();
        int bad = 0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            if (clr_en !== 1'b1 || clr_addr !== 11'(i) || busy !== 1'b1 ||
                inc_en !== 1'b0) begin
                bad++;
            end
        end
        checkOutput("init_sweep_bad_cycles", bad, 0);
        tick();
        checkOutput("init_done_clr_en", clr_en, 0);
        checkOutput("init_done_busy", busy, 0);
        checkOutput("init_drop_count", drop_count, 0);
    endtask

    // Called on the first cycle of CLEAR. Expects 512 clear cycles from
    // base. Optionally pulses a (dropped) event at cycle drop_at. Then checks
    // the FLUSH increment and the return to ACCUM.
    task automatic runClear(input logic [10:0] base, input int drop_at,
                            input logic [10:0] flush_addr);
        int bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (clr_en !== 1'b1 || clr_addr !== base + 11'(k) ||
                inc_en !== 1'b0 || busy !== 1'b1 || win_req !== 1'b0) begin
                bad++;
            end
            if (k == drop_at) begin
                ev_valid = 1'b1;
            end
            tick();
            ev_valid = 1'b0;
        end
        checkOutput("clear_sweep_bad_cycles", bad, 0);
        checkOutput("flush_inc_en", inc_en, 1);
        checkOutput("flush_inc_addr", inc_addr, flush_addr);
        checkOutput("flush_clr_en", clr_en, 0);
        tick();
        checkOutput("post_flush_busy", busy, 0);
        checkOutput("post_flush_inc_en", inc_en, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_inc_en"}, inc_en, 0);
        checkOutput({tag, "_inc_addr"}, inc_addr, 0);
        checkOutput({tag, "_clr_en"}, clr_en, 0);
        checkOutput({tag, "_clr_addr"}, clr_addr, 0);
        checkOutput({tag, "_win_req"}, win_req, 0);
        checkOutput({tag, "_win_oldest"}, win_oldest, 0);
        checkOutput({tag, "_cur_bin"}, cur_bin, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_drop_count"}, drop_count, 0);
    endtask

    initial begin
        int bad;

        // Reset values, then release and check the full init sweep.
        rst = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rst = 1'b1;
        initSweep();
        repeat (3) tick();
        checkOutput("idle_inc_en", inc_en, 0);
        checkOutput("idle_busy", busy, 0);

        // First event starts bin 0, then in-bin, late and boundary events.
        inBinEvent("first", 4'd3, 4'd5, 1'b1, 16'd100, 11'h153, 2'd0);
        tick();
        checkOutput("first_inc_pulse", inc_en, 0);
        inBinEvent("inbin", 4'd2, 4'd1, 1'b0, 16'd600, 11'h012, 2'd0);
        inBinEvent("late", 4'd15, 4'd15, 1'b0, 16'd50, 11'h0FF, 2'd0);
        inBinEvent("edge999", 4'd0, 4'd0, 1'b0, 16'd1099, 11'h000, 2'd0);

        // An ack outside the handshake does nothing.
        win_ack = 1'b1;
        tick();
        win_ack = 1'b0;
        checkOutput("stray_ack_busy", busy, 0);
        checkOutput("stray_ack_win_req", win_req, 0);

        // Rollover 1: the ring is not yet full, so the bin is cleared
        // directly. One event is dropped during the clear.
        applyStimulus(4'd7, 4'd2, 1'b1, 16'd1100);
        checkOutput("roll1_win_req", win_req, 0);
        checkOutput("roll1_cur_bin", cur_bin, 1);
        runClear(11'h200, 10, 11'h327);
        checkOutput("roll1_drop_count", drop_count, 1);

        // Rollovers 2 and 3.
        applyStimulus(4'd4, 4'd4, 1'b0, 16'd2100);
        checkOutput("roll2_cur_bin", cur_bin, 2);
        runClear(11'h400, -1, 11'h444);
        applyStimulus(4'd1, 4'd0, 1'b1, 16'd3100);
        checkOutput("roll3_cur_bin", cur_bin, 3);
        runClear(11'h600, -1, 11'h701);

        // Rollover 4 fills the ring, so the window is requested. The consumer
        // waits 10 cycles while three events arrive and are dropped.
        applyStimulus(4'd6, 4'd9, 1'b0, 16'd4100);
        checkOutput("win1_req", win_req, 1);
        checkOutput("win1_oldest", win_oldest, 0);
        checkOutput("win1_cur_bin", cur_bin, 3);
        checkOutput("win1_busy", busy, 1);
        checkOutput("win1_clr_en", clr_en, 0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (win_req !== 1'b1 || clr_en !== 1'b0 || inc_en !== 1'b0) begin
                bad++;
            end
            if (c == 2 || c == 4 || c == 6) begin
                ev_valid = 1'b1;
            end
            tick();
            ev_valid = 1'b0;
        end
        checkOutput("win1_hold_bad_cycles", bad, 0);
        checkOutput("win1_drop_count", drop_count, 4);
        win_ack = 1'b1;
        tick();
        win_ack = 1'b0;
        checkOutput("win1_req_fall", win_req, 0);
        checkOutput("win1_ack_cur_bin", cur_bin, 0);
        runClear(11'h000, -1, 11'h096);

        // With the ring already full, the next rollover requests again.
        applyStimulus(4'd5, 4'd3, 1'b1, 16'd5100);
        checkOutput("win2_req", win_req, 1);
        checkOutput("win2_oldest", win_oldest, 1);
        win_ack = 1'b1;
        tick();
        win_ack = 1'b0;
        checkOutput("win2_cur_bin", cur_bin, 1);
        checkOutput("win2_clr_start", clr_addr, 11'h200);

        // Reset asserted 200 cycles into the clear.
        repeat (200) tick();
        checkOutput("mid_clear_addr", clr_addr, 11'h2C8);
        checkOutput("mid_clear_drop_count", drop_count, 4);
        rst = 1'b0;
        #1;
        checkAllZero("mid_clear_rst");
        tick();
        rst = 1'b1;
        initSweep();

        // Timestamp wrap: bin starts at 65000, and ts=400 is 936 ticks later.
        inBinEvent("wrap_first", 4'd1, 4'd1, 1'b0, 16'd65000, 11'h011, 2'd0);
        inBinEvent("wrap_same", 4'd2, 4'd2, 1'b1, 16'd400, 11'h122, 2'd0);
        applyStimulus(4'd3, 4'd3, 1'b0, 16'd500);
        checkOutput("wrap_roll_cur_bin", cur_bin, 1);
        runClear(11'h200, -1, 11'h233);
        // The bin start is now 464, so 1463 is still in the bin and 1464
        // rolls over.
        inBinEvent("wrap_edge", 4'd0, 4'd1, 1'b0, 16'd1463, 11'h210, 2'd1);
        applyStimulus(4'd0, 4'd2, 1'b0, 16'd1464);
        checkOutput("wrap_roll2_cur_bin", cur_bin, 2);
        runClear(11'h400, -1, 11'h420);

        // Gap: the bin start is 1464 and ts=6364 is 4900 later. There is a
        // single advance, and the bin start resyncs to 6364.
        applyStimulus(4'd9, 4'd9, 1'b1, 16'd6364);
        checkOutput("gap_cur_bin", cur_bin, 3);
        checkOutput("gap_win_req", win_req, 0);
        runClear(11'h600, -1, 11'h799);
        inBinEvent("gap_same", 4'd0, 4'd0, 1'b0, 16'd7363, 11'h600, 2'd3);
        applyStimulus(4'd0, 4'd0, 1'b0, 16'd7364);
        checkOutput("gap_roll_win_req", win_req, 1);
        checkOutput("gap_roll_oldest", win_oldest, 0);
        win_ack = 1'b1;
        tick();
        win_ack = 1'b0;
        checkOutput("gap_ack_cur_bin", cur_bin, 0);
        checkOutput("gap_ack_drop_count", drop_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
